// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the two-client shift scheduler.
package shift_sched_pkg;

  localparam int DATA_W  = 8;
  localparam int AMT_W   = 4;
  localparam int MAXPASS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sched_right_shift8.sv
// Combinational 8-bit logical right shifter, 0..7 positions per pass.
module right_shift8 (
  input  logic [7:0] data,
  input  logic [2:0] step,
  output logic [7:0] result
);

  assign result = data >> step;

endmodule

// File: rtl/shift_sched.sv
// Round-robin two-client scheduler sharing one right_shift8 datapath.
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high; a valid source holds its payload until that edge.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int NCLIENT = 2,
  parameter int MAXPASS = shift_sched_pkg::MAXPASS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NCLIENT-1:0]              req_valid,
  input  logic [NCLIENT-1:0][DATA_W-1:0]  req_data,
  input  logic [NCLIENT-1:0][AMT_W-1:0]   req_amt,
  output logic [NCLIENT-1:0]              req_ready,
  output logic                            resp_valid,
  output logic [DATA_W-1:0]               resp_data,
  output logic                            resp_id,
  input  logic                            resp_ready,
  output logic                            busy
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic                id_q, id_d;
  logic                rr_q, rr_d;

  logic                grant;
  logic                grant_vld;
  logic [2:0]          step;
  logic [DATA_W-1:0]   shifted;

  // Amounts above one pass are consumed MAXPASS at a time.
  assign step = (rem_q > AMT_W'(MAXPASS)) ? 3'(MAXPASS) : rem_q[2:0];

  right_shift8 u_shift (
    .data   (op_q),
    .step   (step),
    .result (shifted)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    id_d      = id_q;
    rr_d      = rr_q;
    req_ready = '0;
    grant     = rr_q;
    grant_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid[rr_q]) begin
          grant     = rr_q;
          grant_vld = 1'b1;
        end else if (req_valid[~rr_q]) begin
          grant     = ~rr_q;
          grant_vld = 1'b1;
        end
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
          op_d    = req_data[grant];
          rem_d   = req_amt[grant];
          id_d    = grant;
          rr_d    = ~grant;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        op_d  = shifted;
        rem_d = rem_q - AMT_W'(step);
        if (rem_d == '0) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      rem_q   <= '0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  // Response fields come straight from registers, so no input reaches them combinationally.
  assign resp_valid = (state_q == RESP);
  assign resp_data  = op_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != IDLE);

endmodule
